// File: rtl/fpu_ret_collect.sv
// fpu_ret_collect: multi-write FIFO collecting u1/u3/u5 FP retire codes, drained one per cycle with issue stall.
// Optional FPU_RET_PERF_EN adds perf_push_cnt / perf_stall_cnt counters.
module fpu_ret_collect #(
    parameter int DEPTH = 16,
    parameter int PTRW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [13:0]     u1_ret,
    input  logic            u1_ret_en,
    input  logic [13:0]     u3_ret,
    input  logic            u3_ret_en,
    input  logic [13:0]     u5_ret,
    input  logic            u5_ret_en,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [13:0]     out_ret,
    output logic [1:0]      out_port,
    output logic            fp_stall,
    output logic            ovf_err,
    output logic [PTRW:0]   count
`ifdef FPU_RET_PERF_EN
    ,
    output logic [31:0]     perf_push_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);
    logic [13:0]   mem_ret  [DEPTH];
    logic [1:0]    mem_port [DEPTH];
    logic [PTRW-1:0] rd_ptr, wr_ptr;
    logic [PTRW:0] free, k3, k5, nreq, nacc, count_next;
    logic          pop, acc1, acc3, acc5;

    assign out_vld  = count != '0;
    assign out_ret  = out_vld ? mem_ret[rd_ptr] : 14'd0;
    assign out_port = out_vld ? mem_port[rd_ptr] : 2'd0;
    assign pop      = out_vld & out_rdy;

    // k3/k5 are the compacted slot offsets; an entry is accepted only if its offset fits in free space
    always_comb begin
        free       = (PTRW+1)'(DEPTH) - count + (PTRW+1)'(pop);
        k3         = (PTRW+1)'(u1_ret_en);
        k5         = k3 + (PTRW+1)'(u3_ret_en);
        nreq       = k5 + (PTRW+1)'(u5_ret_en);
        acc1       = u1_ret_en && free > '0;
        acc3       = u3_ret_en && free > k3;
        acc5       = u5_ret_en && free > k5;
        nacc       = (PTRW+1)'(acc1) + (PTRW+1)'(acc3) + (PTRW+1)'(acc5);
        count_next = count + nacc - (PTRW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (acc1) begin
            mem_ret[wr_ptr]  <= u1_ret;
            mem_port[wr_ptr] <= 2'd0;
        end
        if (acc3) begin
            mem_ret[wr_ptr + k3[PTRW-1:0]]  <= u3_ret;
            mem_port[wr_ptr + k3[PTRW-1:0]] <= 2'd1;
        end
        if (acc5) begin
            mem_ret[wr_ptr + k5[PTRW-1:0]]  <= u5_ret;
            mem_port[wr_ptr + k5[PTRW-1:0]] <= 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fp_stall <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr + PTRW'(pop);
            wr_ptr   <= wr_ptr + nacc[PTRW-1:0];
            count    <= count_next;
            fp_stall <= count_next >= (PTRW+1)'(DEPTH - 6);
            ovf_err  <= ovf_err | (nreq > nacc);
        end
    end

`ifdef FPU_RET_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_push_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_push_cnt  <= perf_push_cnt + 32'(nacc);
            perf_stall_cnt <= perf_stall_cnt + 32'(fp_stall);
        end
    end
`endif
endmodule

// File: tb/tb_fpu_ret_collect.sv
// tb_fpu_ret_collect: randomized and directed checks of fpu_ret_collect against a queue-based model.
module tb_fpu_ret_collect;
    localparam int DEPTH = 16;
    localparam int PTRW  = 4;
    logic clk = 0, rst;
    logic [13:0] u1_ret, u3_ret, u5_ret, out_ret;
    logic u1_ret_en, u3_ret_en, u5_ret_en, out_rdy, out_vld, fp_stall, ovf_err;
    logic [1:0] out_port;
    logic [PTRW:0] count;
`ifdef FPU_RET_PERF_EN
    logic [31:0] perf_push_cnt, perf_stall_cnt;
`endif
    int checks = 0, errors = 0;
    logic [15:0] q[$];
    bit m_ovf, m_stall;
    int m_push, m_stallcnt;

    fpu_ret_collect #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk(clk), .rst(rst),
        .u1_ret(u1_ret), .u1_ret_en(u1_ret_en),
        .u3_ret(u3_ret), .u3_ret_en(u3_ret_en),
        .u5_ret(u5_ret), .u5_ret_en(u5_ret_en),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_ret(out_ret), .out_port(out_port),
        .fp_stall(fp_stall), .ovf_err(ovf_err), .count(count)
`ifdef FPU_RET_PERF_EN
        , .perf_push_cnt(perf_push_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit e1, input logic [13:0] v1, input bit e3, input logic [13:0] v3,
                         input bit e5, input logic [13:0] v5, input bit rdy);
        u1_ret_en = e1; u1_ret = v1;
        u3_ret_en = e3; u3_ret = v3;
        u5_ret_en = e5; u5_ret = v5;
        out_rdy = rdy;
    endtask

    // advance the model by one cycle from the current inputs, clock the DUT, compare
    task automatic step();
        logic [15:0] req[$];
        int free;
        bit pop;
        if (rst) begin
            q.delete(); m_ovf = 0; m_stall = 0; m_push = 0; m_stallcnt = 0;
        end else begin
            if (m_stall) m_stallcnt++;
            pop = q.size() != 0 && out_rdy;
            free = DEPTH - q.size() + int'(pop);
            if (pop) void'(q.pop_front());
            if (u1_ret_en) req.push_back({2'd0, u1_ret});
            if (u3_ret_en) req.push_back({2'd1, u3_ret});
            if (u5_ret_en) req.push_back({2'd2, u5_ret});
            foreach (req[i])
                if (i < free) begin q.push_back(req[i]); m_push++; end
                else m_ovf = 1;
            m_stall = q.size() >= DEPTH - 6;
        end
        @(posedge clk); #1;
        chk("count", 32'(count), q.size());
        chk("out_vld", 32'(out_vld), 32'(q.size() != 0));
        chk("out_ret", 32'(out_ret), q.size() != 0 ? 32'(q[0][13:0]) : 0);
        chk("out_port", 32'(out_port), q.size() != 0 ? 32'(q[0][15:14]) : 0);
        chk("fp_stall", 32'(fp_stall), 32'(m_stall));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
`ifdef FPU_RET_PERF_EN
        chk("perf_push", perf_push_cnt, m_push);
        chk("perf_stall", perf_stall_cnt, m_stallcnt);
`endif
    endtask

    initial begin
        int need, cyc;
        bit e1, e3, e5;
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step(); step();
        rst = 0;
        chk("rst_count", 32'(count), 0);
        chk("rst_vld", 32'(out_vld), 0);

        drive(0, 0, 1, 14'h1A5, 0, 0, 1); step();
        chk("t1_ret", 32'(out_ret), 32'h1A5);
        chk("t1_port", 32'(out_port), 1);
        drive(0, 0, 0, 0, 0, 0, 1); step();
        chk("t1_empty", 32'(out_vld), 0);

        drive(1, 14'h0001, 0, 14'h3FFF, 1, 14'h0005, 0); step();
        chk("t2_count", 32'(count), 2);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t2_head0", 32'({out_port, out_ret}), 32'h0001);
        step();
        chk("t2_head1", 32'({out_port, out_ret}), 32'h8005);
        step();
        chk("t2_count0", 32'(count), 0);

        for (int c = 1; c <= 6; c++) begin
            drive(1, 14'($urandom), 1, 14'($urandom), 1, 14'($urandom), 0);
            step();
            if (c == 1) begin chk("t3_c1_count", 32'(count), 3); chk("t3_c1_stall", 32'(fp_stall), 0); end
            if (c == 3) chk("t3_c3_stall", 32'(fp_stall), 0);
            if (c == 4) begin chk("t3_c4_count", 32'(count), 12); chk("t3_c4_stall", 32'(fp_stall), 1); end
            if (c == 6) begin chk("t3_c6_count", 32'(count), 16); chk("t3_c6_ovf", 32'(ovf_err), 1); end
        end

        drive(0, 0, 0, 0, 1, 14'h2222, 1); step();
        chk("t4_count", 32'(count), 16);

        rst = 1; step(); rst = 0;
        drive(1, 1, 1, 2, 1, 3, 0); step(); step(); step();
        drive(1, 4, 0, 0, 0, 0, 0); step();
        chk("t5_fill", 32'(count), 10);
        rst = 1; drive(1, 14'h777, 0, 0, 0, 0, 0); step(); rst = 0;
        chk("t5_count", 32'(count), 0);
        chk("t5_vld", 32'(out_vld), 0);
        chk("t5_stall", 32'(fp_stall), 0);
        chk("t5_ovf", 32'(ovf_err), 0);
        drive(0, 0, 0, 0, 0, 0, 0); step();
        chk("t5_discard", 32'(count), 0);

        rst = 1; step(); rst = 0;
        cyc = 0;
        while (m_push < 40 && cyc < 2000) begin
            need = 40 - m_push;
            e1 = $urandom_range(0, 1) && need > 0;
            e3 = $urandom_range(0, 1) && need > int'(e1);
            e5 = $urandom_range(0, 1) && need > int'(e1) + int'(e3);
            drive(e1, 14'($urandom), e3, 14'($urandom), e5, 14'($urandom), 1'($urandom_range(0, 1)));
            step();
            cyc++;
        end
        chk("t6_pushed", m_push, 40);
        cyc = 0;
        drive(0, 0, 0, 0, 0, 0, 1);
        while (q.size() != 0 && cyc < 100) begin step(); cyc++; end
        chk("t6_drained", 32'(count), 0);
`ifdef FPU_RET_PERF_EN
        chk("t6_perf_push", perf_push_cnt, 40);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
